issue_ctrl: RTL and testbench

Issue/interlock controller for the in-order pipeline; decides each cycle whether the instruction in ID advances into ID/EX.
- Keeps a per-register scoreboard of in-flight writers.
- Sequences multi-cycle MUL/MULHU occupancy of EX.
- Sequences branch redirect flushes and global memory stalls.
- Drives IF/ID stall, ID/EX bubble and flush controls.

---
 rtl/issue_if.sv | 36 +++
 rtl/issue_ctrl.sv | 93 +++++++++
 tb/tb_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_if.sv
// issue_if: ID-stage issue/interlock bus between the pipeline and issue_ctrl
// master: pipeline side, drives the ID/EX/MEM status and receives the controls
// slave : issue_ctrl side
interface issue_if;
  logic        id_valid_inst;
  logic [4:0]  id_ra_idx;
  logic [4:0]  id_rb_idx;
  logic        id_uses_ra;
  logic        id_uses_rb;
  logic        id_reg_wr;
  logic [4:0]  id_dest_idx;
  logic        id_rd_mem;
  logic        id_is_mul;
  logic        ex_take_branch;
  logic        mem_stall;
  logic        if_stall;
  logic        id_stall;
  logic        issue;
  logic        id_ex_bubble;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        ex_busy;
  logic [31:0] pending_mask;
  modport master(
    output id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb, id_reg_wr,
           id_dest_idx, id_rd_mem, id_is_mul, ex_take_branch, mem_stall,
    input  if_stall, id_stall, issue, id_ex_bubble, flush_if_id, flush_id_ex,
           ex_busy, pending_mask
  );
  modport slave(
    input  id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb, id_reg_wr,
           id_dest_idx, id_rd_mem, id_is_mul, ex_take_branch, mem_stall,
    output if_stall, id_stall, issue, id_ex_bubble, flush_if_id, flush_id_ex,
           ex_busy, pending_mask
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue/interlock controller (scoreboard, MUL occupancy, flush/stall sequencing)
// Ports: clk; rst (asynchronous, active-low); bus (issue_if.slave) carrying the ID operand/dest
//   info, ex_take_branch, mem_stall in, and if_stall/id_stall/issue/id_ex_bubble/flushes/
//   ex_busy/pending_mask out. All outputs are 0 while rst is low.
// Option: define BYPASS_EN to interlock only on load-use; otherwise full interlock.
module issue_ctrl #(
  parameter int WB_DIST = 3,
  parameter int MUL_LAT = 2
) (
  input logic     clk,
  input logic     rst,
  issue_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] LP_WB = 2'(WB_DIST);
  localparam logic [2:0] LP_ML = 3'(MUL_LAT);
  state_t      r_state, w_state_nx;
  logic [2:0]  r_mcnt, w_mcnt_nx;
  logic [1:0]  r_cnt [32];
  logic [31:0] w_pend, w_blk;
  logic        w_busy, w_run, w_br, w_hazard, w_wr, w_issue;
`ifdef BYPASS_EN
  logic [31:0] r_tag;
`else
  logic        w_unused_rd_mem;
  assign w_unused_rd_mem = bus.id_rd_mem;
`endif
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      w_pend[r] = r_cnt[r] != 2'd0;
`ifdef BYPASS_EN
      // only a load still one cycle from its result blocks; everything else forwards
      w_blk[r] = r_tag[r] && r_cnt[r] == LP_WB;
`else
      w_blk[r] = w_pend[r];
`endif
    end
  end
  assign w_busy   = r_state == BUSY;
  assign w_run    = ~bus.mem_stall & ~w_busy;
  // EX cannot resolve a branch while a MUL occupies it
  assign w_br     = bus.ex_take_branch & ~w_busy;
  assign w_hazard = (bus.id_uses_ra && bus.id_ra_idx != 5'd0 && w_blk[bus.id_ra_idx]) ||
                    (bus.id_uses_rb && bus.id_rb_idx != 5'd0 && w_blk[bus.id_rb_idx]);
  assign w_issue  = rst & w_run & ~w_br & ~w_hazard & bus.id_valid_inst;
  assign w_wr     = w_issue & bus.id_reg_wr;
  assign bus.if_stall     = rst & (bus.mem_stall | (~w_br & (w_busy | (w_hazard & bus.id_valid_inst))));
  assign bus.id_stall     = bus.if_stall;
  assign bus.issue        = w_issue;
  assign bus.id_ex_bubble = rst & w_run & ~w_br & (w_hazard | ~bus.id_valid_inst);
  assign bus.flush_if_id  = rst & ~bus.mem_stall & w_br;
  assign bus.flush_id_ex  = bus.flush_if_id;
  assign bus.ex_busy      = rst & w_busy;
  assign bus.pending_mask = rst ? w_pend : 32'd0;
  // r_cnt[0] is only ever reset, so x0 never reads as pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) r_cnt[r] <= 2'd0;
    end else begin
      for (int r = 1; r < 32; r++)
        if (w_wr && bus.id_dest_idx == 5'(r)) r_cnt[r] <= LP_WB;
        else if (w_run && r_cnt[r] != 2'd0) r_cnt[r] <= r_cnt[r] - 2'd1;
    end
  end
`ifdef BYPASS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tag <= '0;
    else if (w_wr && bus.id_dest_idx != 5'd0) r_tag[bus.id_dest_idx] <= bus.id_rd_mem;
  end
`endif
  always_comb begin
    w_state_nx = r_state;
    w_mcnt_nx  = r_mcnt;
    if (r_state == IDLE) begin
      if (w_issue && bus.id_is_mul) begin
        w_state_nx = BUSY;
        w_mcnt_nx  = LP_ML;
      end
    end else if (!bus.mem_stall) begin
      w_mcnt_nx  = r_mcnt - 3'd1;
      w_state_nx = r_mcnt == 3'd1 ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_mcnt  <= w_mcnt_nx;
    end
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed and randomized checks of issue_ctrl against a timestamp reference model
module tb_issue_ctrl;
  localparam int WB = 3, ML = 2;
  logic clk = 1'b0, rst = 1'b0;
  int n_chk = 0, n_fail = 0;
  // reference model: each register records the unfrozen-cycle time its result is ready
  int ready [32];
  bit ld [32];
  int t = 0, busy_left = 0;
  issue_if bus();
  issue_ctrl #(.WB_DIST(WB), .MUL_LAT(ML)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  function automatic bit blk(logic [4:0] r);
`ifdef BYPASS_EN
    return r != 0 && ld[r] && (ready[r] - t) == WB;
`else
    return r != 0 && ready[r] > t;
`endif
  endfunction
  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++) m[r] = ready[r] > t;
    return m;
  endfunction
  // {if_stall, id_stall, issue, bubble, flush_if_id, flush_id_ex, ex_busy}
  function automatic logic [6:0] predict();
    bit busy = busy_left > 0;
    bit hz = (bus.id_uses_ra && blk(bus.id_ra_idx)) || (bus.id_uses_rb && blk(bus.id_rb_idx));
    if (!rst) return '0;
    if (bus.mem_stall) return {6'b110000, busy};
    if (bus.ex_take_branch && !busy) return 7'b0000110;
    if (busy) return 7'b1100001;
    if (hz && bus.id_valid_inst) return 7'b1101000;
    return {2'b00, bus.id_valid_inst, !bus.id_valid_inst, 3'b000};
  endfunction
  function automatic logic [6:0] got();
    return {bus.if_stall, bus.id_stall, bus.issue, bus.id_ex_bubble,
            bus.flush_if_id, bus.flush_id_ex, bus.ex_busy};
  endfunction
  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin ready[r] = 0; ld[r] = 0; end
    t = 0;
    busy_left = 0;
  endtask
  task automatic model_step();
    logic [6:0] e = predict();
    bit run = !bus.mem_stall && busy_left == 0;
    if (e[4] && bus.id_reg_wr && bus.id_dest_idx != 0) begin
      ready[bus.id_dest_idx] = t + int'(run) + WB;
      ld[bus.id_dest_idx] = bus.id_rd_mem;
    end
    if (busy_left > 0) begin
      if (!bus.mem_stall) busy_left--;
    end else if (e[4] && bus.id_is_mul) busy_left = ML;
    if (run) t++;
  endtask
  task automatic set_id(bit v, logic [4:0] a, logic [4:0] b, bit ua, bit ub, bit wr,
                        logic [4:0] d, bit ldm, bit mul);
    bus.id_valid_inst = v; bus.id_ra_idx = a; bus.id_rb_idx = b;
    bus.id_uses_ra = ua; bus.id_uses_rb = ub; bus.id_reg_wr = wr;
    bus.id_dest_idx = d; bus.id_rd_mem = ldm; bus.id_is_mul = mul;
  endtask
  task automatic set_ctl(bit br, bit ms);
    bus.ex_take_branch = br;
    bus.mem_stall = ms;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0);
    repeat (n) adv();
  endtask
  task automatic test_reset();
    model_reset();
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 1);
    set_ctl(0, 0);
    settle();
    n_chk++;
    if (got() !== 7'b0) begin n_fail++; $display("FAIL reset_outputs got %b want 0000000", got()); end
    n_chk++;
    if (bus.pending_mask !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", bus.pending_mask); end
    idle(0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask
  task automatic test_raw();
    idle(6);
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 0);
    settle();
    n_chk++;
    if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL raw_producer_issue got %b want 1", bus.issue); end
    adv();
    set_id(1, 5, 1, 1, 1, 1, 6, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      settle();
      n_chk++;
      if ({bus.id_stall, bus.id_ex_bubble, bus.issue} !== (i < 4 ? 3'b110 : 3'b001)) begin
        n_fail++; $display("FAIL raw_cycle%0d stall/bubble/issue got %b%b%b", i, bus.id_stall, bus.id_ex_bubble, bus.issue);
      end
      n_chk++;
      if (bus.pending_mask[5] !== 1'(i < 4)) begin
        n_fail++; $display("FAIL raw_mask5 cycle%0d got %b want %b", i, bus.pending_mask[5], i < 4);
      end
      adv();
    end
  endtask
  task automatic test_x0();
    idle(6);
    set_id(1, 0, 0, 0, 0, 1, 0, 0, 0);
    settle();
    n_chk++;
    if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL x0_write_issue got %b want 1", bus.issue); end
    adv();
    set_id(1, 0, 0, 1, 1, 1, 9, 0, 0);
    settle();
    n_chk++;
    if ({bus.issue, bus.id_stall} !== 2'b10) begin
      n_fail++; $display("FAIL x0_read issue/stall got %b%b want 10", bus.issue, bus.id_stall);
    end
    n_chk++;
    if (bus.pending_mask !== 32'h0) begin n_fail++; $display("FAIL x0_mask got %h want 0", bus.pending_mask); end
    adv();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    n_chk++;
    if (bus.pending_mask !== 32'h200) begin n_fail++; $display("FAIL x9_mask got %h want 00000200", bus.pending_mask); end
    adv();
  endtask
  task automatic test_mul();
    idle(6);
    set_id(1, 1, 2, 1, 1, 1, 7, 0, 1);
    settle();
    n_chk++;
    if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL mul_issue got %b want 1", bus.issue); end
    adv();
    set_id(1, 7, 0, 1, 0, 1, 8, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      settle();
      n_chk++;
      if ({bus.ex_busy, bus.id_stall, bus.id_ex_bubble, bus.issue} !==
          (i <= 2 ? 4'b1100 : i <= 5 ? 4'b0110 : 4'b0001)) begin
        n_fail++; $display("FAIL mul_cycle%0d busy/stall/bubble/issue got %b%b%b%b", i,
                           bus.ex_busy, bus.id_stall, bus.id_ex_bubble, bus.issue);
      end
      adv();
    end
  endtask
  task automatic test_branch();
    idle(6);
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 0);
    adv();
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      set_ctl(i == 2, 0);
      settle();
      n_chk++;
      if ({bus.flush_if_id, bus.flush_id_ex, bus.issue, bus.id_stall, bus.id_ex_bubble} !==
          (i == 2 ? 5'b11000 : i == 4 ? 5'b00100 : 5'b00011)) begin
        n_fail++; $display("FAIL branch_cycle%0d flush/flush/issue/stall/bubble got %b%b%b%b%b", i,
                           bus.flush_if_id, bus.flush_id_ex, bus.issue, bus.id_stall, bus.id_ex_bubble);
      end
      adv();
    end
    set_ctl(0, 0);
  endtask
  task automatic test_mem_stall();
    idle(6);
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 0);
    adv();
    set_id(1, 0, 5, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      set_ctl(0, i >= 2 && i <= 5);
      settle();
      n_chk++;
      if ({bus.if_stall, bus.id_stall, bus.id_ex_bubble, bus.issue} !==
          (bus.mem_stall ? 4'b1100 : i < 8 ? 4'b1110 : 4'b0001)) begin
        n_fail++; $display("FAIL memstall_cycle%0d ifst/idst/bubble/issue got %b%b%b%b", i,
                           bus.if_stall, bus.id_stall, bus.id_ex_bubble, bus.issue);
      end
      n_chk++;
      if (bus.pending_mask[5] !== 1'(i < 8)) begin
        n_fail++; $display("FAIL memstall_mask5 cycle%0d got %b want %b", i, bus.pending_mask[5], i < 8);
      end
      adv();
    end
    set_ctl(0, 0);
  endtask
  task automatic test_reset_mid_mul();
    idle(6);
    set_id(1, 1, 2, 1, 1, 1, 7, 0, 1);
    adv();
    set_id(1, 7, 0, 1, 0, 0, 0, 0, 0);
    settle();
    n_chk++;
    if (bus.ex_busy !== 1'b1) begin n_fail++; $display("FAIL midmul_busy got %b want 1", bus.ex_busy); end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (got() !== 7'b0) begin n_fail++; $display("FAIL midmul_reset_outputs got %b want 0000000", got()); end
    n_chk++;
    if (bus.pending_mask !== 32'h0) begin n_fail++; $display("FAIL midmul_reset_mask got %h want 0", bus.pending_mask); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask
`ifdef BYPASS_EN
  task automatic test_bypass();
    idle(6);
    set_id(1, 1, 2, 1, 1, 1, 5, 1, 0);
    adv();
    set_id(1, 5, 0, 1, 0, 1, 6, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      settle();
      n_chk++;
      if ({bus.id_stall, bus.id_ex_bubble, bus.issue} !== (i == 1 ? 3'b110 : 3'b001)) begin
        n_fail++; $display("FAIL loaduse_cycle%0d stall/bubble/issue got %b%b%b", i, bus.id_stall, bus.id_ex_bubble, bus.issue);
      end
      adv();
    end
    set_id(1, 6, 0, 1, 0, 0, 0, 0, 0);
    settle();
    n_chk++;
    if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL alu_forward_issue got %b want 1", bus.issue); end
    adv();
  endtask
`endif
  task automatic test_random();
    logic [6:0] e;
    idle(6);
    for (int k = 0; k < 400; k++) begin
      set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      settle();
      e = predict();
      n_chk++;
      if (got() !== e) begin n_fail++; $display("FAIL rand%0d outputs got %b want %b", k, got(), e); end
      n_chk++;
      if (bus.pending_mask !== exp_mask()) begin
        n_fail++; $display("FAIL rand%0d mask got %h want %h", k, bus.pending_mask, exp_mask());
      end
      adv();
    end
    idle(2);
  endtask
  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_mul();
    test_branch();
    test_mem_stall();
    test_reset_mid_mul();
`ifdef BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
